fetch_mt: RTL and testbench

Multithreaded fetch/load-store unit: arbitrates memory requests from THREADS hardware threads onto one single-master bus port using round-robin priority, with a per-transaction bus timeout. Sits between the per-thread CPU pipeline front ends and the SoC system bus; parametrised successor to the single-port fetch unit. Supports both read (fetch/load) and write (store) transactions and reports a bus error when a slave does not answer in time.

---
 rtl/fetch_mt.sv | 134 +++++++++++++
 tb/tb_fetch_mt.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_mt.sv
// Multithreaded fetch/load-store unit: round-robin arbitration of per-thread
// memory requests onto a single-master bus port with a per-transaction timeout.
module fetch_mt #(
    parameter int unsigned THREADS = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [THREADS-1:0]            req_valid,
    input  logic [THREADS-1:0]            req_write,
    input  logic [THREADS*AW-1:0]         req_addr,
    input  logic [THREADS*DW-1:0]         req_wdata,
    output logic [THREADS-1:0]            req_ack,
    output logic [THREADS-1:0]            req_err,
    output logic [DW-1:0]                 rdata,
    output logic [$clog2(THREADS)-1:0]    resp_thread,
    output logic                          bus_cyc,
    output logic                          bus_we,
    output logic [AW-1:0]                 bus_addr,
    output logic [DW-1:0]                 bus_wdata,
    input  logic                          bus_ack,
    input  logic [DW-1:0]                 bus_rdata
);

    localparam int unsigned PW   = $clog2(THREADS);
    localparam int unsigned TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TERM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [PW-1:0]      ptr;
    logic [TW-1:0]      timer;
    logic               resp_err;

    logic [THREADS-1:0] cand;
    logic               gnt_found;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      idx;

    logic [AW-1:0]      addr_arr  [THREADS];
    logic [DW-1:0]      wdata_arr [THREADS];

    for (genvar g = 0; g < THREADS; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*AW +: AW];
        assign wdata_arr[g] = req_wdata[g*DW +: DW];
    end

    // A thread whose completion pulse is visible this cycle is dropping its
    // request on the next edge, so it must not be granted again now.
    assign cand = req_valid & ~(req_ack | req_err);

    // Round-robin pick: first candidate at or above ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int i = THREADS - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % THREADS);
            if (cand[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            timer       <= '0;
            resp_err    <= 1'b0;
            req_ack     <= '0;
            req_err     <= '0;
            rdata       <= '0;
            resp_thread <= '0;
            bus_cyc     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
        end else begin
            req_ack <= '0;
            req_err <= '0;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        resp_thread <= gnt_idx;
                        bus_we      <= req_write[gnt_idx];
                        bus_addr    <= addr_arr[gnt_idx];
                        bus_wdata   <= wdata_arr[gnt_idx];
                        bus_cyc     <= 1'b1;
                        timer       <= '0;
                        state       <= BUS;
                    end
                end
                BUS: begin
                    // Ack takes precedence over a coincident timeout.
                    if (bus_ack) begin
                        rdata    <= bus_we ? '0 : bus_rdata;
                        bus_cyc  <= 1'b0;
                        bus_we   <= 1'b0;
                        resp_err <= 1'b0;
                        state    <= RESP;
                    end else if ((TIMEOUT != 0) && (timer == TW'(TERM))) begin
                        rdata    <= '0;
                        bus_cyc  <= 1'b0;
                        bus_we   <= 1'b0;
                        resp_err <= 1'b1;
                        state    <= RESP;
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP: begin
                    if (resp_err) begin
                        req_err[resp_thread] <= 1'b1;
                    end else begin
                        req_ack[resp_thread] <= 1'b1;
                    end
                    ptr   <= (resp_thread == PW'(THREADS - 1)) ? '0 : resp_thread + PW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_mt.sv
// Directed bench for fetch_mt: vector table of single transactions plus
// reset-mid-transaction and round-robin sequences.
module tb_fetch_mt;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_write;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   req_ack;
    logic [3:0]   req_err;
    logic [31:0]  rdata;
    logic [1:0]   resp_thread;
    logic         bus_cyc;
    logic         bus_we;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic         bus_ack;
    logic [31:0]  bus_rdata;

    int n_total = 0;
    int n_pass  = 0;

    fetch_mt #(.THREADS(4), .AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ack     (req_ack),
        .req_err     (req_err),
        .rdata       (rdata),
        .resp_thread (resp_thread),
        .bus_cyc     (bus_cyc),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  thr;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] srdata;
        int          dly;
        int          exp_ncyc;
        logic [3:0]  exp_ack;
        logic [3:0]  exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int  ncyc;
        bit  seen;
        @(negedge clk);
        req_valid = '0;
        req_valid[v.thr] = 1'b1;
        req_write[v.thr] = v.wr;
        req_addr[v.thr*32 +: 32]  = v.addr;
        req_wdata[v.thr*32 +: 32] = v.wdata;
        bus_ack = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = bus_cyc;
        end
        check($sformatf("v%0d_grant", n), 32'(seen), 32'd1);
        check($sformatf("v%0d_addr", n), bus_addr, v.addr);
        check($sformatf("v%0d_we", n), 32'(bus_we), 32'(v.wr));
        if (v.wr) check($sformatf("v%0d_wdata", n), bus_wdata, v.wdata);
        check($sformatf("v%0d_thr_grant", n), 32'(resp_thread), 32'(v.thr));
        ncyc = 0;
        while (bus_cyc && ncyc < 20) begin
            ncyc++;
            bus_ack   = ((ncyc - 1) == v.dly);
            bus_rdata = bus_ack ? v.srdata : 32'h5555_5555;
            @(negedge clk);
        end
        bus_ack = 1'b0;
        check($sformatf("v%0d_ncyc", n), 32'(ncyc), 32'(v.exp_ncyc));
        check($sformatf("v%0d_ack_early", n), 32'(req_ack | req_err), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_ack", n), 32'(req_ack), 32'(v.exp_ack));
        check($sformatf("v%0d_err", n), 32'(req_err), 32'(v.exp_err));
        check($sformatf("v%0d_rdata", n), rdata, v.exp_rdata);
        check($sformatf("v%0d_thr_resp", n), 32'(resp_thread), 32'(v.thr));
        req_valid = '0;
        @(negedge clk);
        check($sformatf("v%0d_pulse_end", n), 32'(req_ack | req_err), 32'd0);
    endtask

    initial begin
        int  gcyc [5];
        logic [1:0]  gthr [5];
        logic [31:0] gaddr [5];
        int  g;
        bit  prev;
        bit  bad;
        bit  seen;

        vecs[0] = '{2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 4, 4'b0100, 4'b0000, 32'hDEAD_BEEF};
        vecs[1] = '{2'd1, 1'b0, 32'h0000_0044, 32'h0, 32'h1111_1111, 99, 8, 4'b0000, 4'b0010, 32'h0};
        vecs[2] = '{2'd0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hFFFF_FFFF, 0, 1, 4'b0001, 4'b0000, 32'h0};
        vecs[3] = '{2'd3, 1'b0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 7, 8, 4'b1000, 4'b0000, 32'hCAFE_F00D};
        vecs[4] = '{2'd1, 1'b0, 32'h0000_01FC, 32'h0, 32'h0000_A5A5, 6, 7, 4'b0010, 4'b0000, 32'h0000_A5A5};
        vecs[5] = '{2'd3, 1'b1, 32'h0000_0400, 32'hFEED_FACE, 32'h1212_1212, 2, 3, 4'b1000, 4'b0000, 32'h0};

        rst_n = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        repeat (2) @(negedge clk);

        check("rst_bus_cyc", 32'(bus_cyc), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_ack_err", 32'({req_ack, req_err}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp_thread", 32'(resp_thread), 32'd0);
        rst_n = 1'b1;

        // Stray ack while idle must be ignored.
        bus_ack = 1'b1;
        bus_rdata = 32'h9999_9999;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("idle_ack_cyc%0d", k), 32'(bus_cyc), 32'd0);
            check($sformatf("idle_ack_resp%0d", k), 32'({req_ack, req_err}), 32'd0);
        end
        bus_ack = 1'b0;
        check("idle_ack_rdata", rdata, 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset in the middle of a bus transaction.
        @(negedge clk);
        req_addr[3*32 +: 32] = 32'h0000_0300;
        req_write = '0;
        req_valid = 4'b1000;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = bus_cyc;
        end
        check("mid_grant", 32'(seen), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_cyc_async", 32'(bus_cyc), 32'd0);
        check("mid_rst_no_resp", 32'({req_ack, req_err}), 32'd0);
        req_addr[1*32 +: 32] = 32'h0000_1100;
        req_valid = 4'b1010;
        @(negedge clk);
        check("mid_rst_hold_resp", 32'({req_ack, req_err}), 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = bus_cyc;
            if (!seen) check($sformatf("mid_post_no_resp%0d", k), 32'({req_ack, req_err}), 32'd0);
        end
        check("mid_post_grant", 32'(seen), 32'd1);
        check("mid_post_thr", 32'(resp_thread), 32'd1);
        check("mid_post_addr", bus_addr, 32'h0000_1100);
        bus_ack = 1'b1;
        bus_rdata = 32'h0000_0077;
        @(negedge clk);
        bus_ack = 1'b0;
        @(negedge clk);
        check("mid_post_ack", 32'(req_ack), 32'b0010);
        check("mid_post_rdata", rdata, 32'h0000_0077);
        req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // All threads requesting continuously against a zero-wait slave.
        for (int t = 0; t < 4; t++) req_addr[t*32 +: 32] = 32'h1000 * t + 32'h10;
        req_write = '0;
        req_valid = 4'b1111;
        bus_ack   = 1'b1;
        bus_rdata = 32'h0;
        g = 0;
        prev = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 60 && g < 5; c++) begin
            @(negedge clk);
            if (bus_cyc && !prev) begin
                gthr[g]  = resp_thread;
                gaddr[g] = bus_addr;
                gcyc[g]  = c;
                g++;
            end
            prev = bus_cyc;
            if (!$onehot0(req_ack | req_err) || (req_err != 4'b0) || ((req_ack & req_err) != 4'b0)) bad = 1'b1;
        end
        check("rr_grants", 32'(g), 32'd5);
        for (int k = 0; k < g; k++) begin
            check($sformatf("rr_thr%0d", k), 32'(gthr[k]), 32'(k % 4));
            check($sformatf("rr_addr%0d", k), gaddr[k], 32'h1000 * (k % 4) + 32'h10);
            if (k > 0) check($sformatf("rr_gap%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'd3);
        end
        if (g == 5) check("rr_period_t0", 32'(gcyc[4] - gcyc[0]), 32'd12);
        check("rr_pulses", 32'(bad), 32'd0);
        req_valid = '0;
        bus_ack = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
